// File: rtl/t06_tick_pkg.sv
// rtl/t06_tick_pkg.sv - shared constants, types and round-robin helper for the tick scheduler
package t06_tick_pkg;

    localparam int NCH = 4;
    localparam int CHW = 2;
    localparam int PW  = 8;
    localparam int PRW = 19;

    typedef logic [CHW-1:0] ch_idx_t;
    typedef logic [PW-1:0]  period_t;

    typedef struct packed {
        period_t reload;
        logic    en;
        logic    oneshot;
    } chan_cfg_t;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // First requesting channel at or after ptr, wrapping; returns ptr when nothing requests.
    function automatic ch_idx_t rr_pick(input logic [NCH-1:0] req, input ch_idx_t ptr);
        ch_idx_t sel;
        logic    found;
        int      idx;
        sel   = ptr;
        found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            idx = (int'(ptr) + i) % NCH;
            if (!found && req[idx]) begin
                sel   = ch_idx_t'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/t06_prescaler.sv
// rtl/t06_prescaler.sv - shared base-tick prescaler, one-clock tick every max_i+1 clocks
module t06_prescaler
    import t06_tick_pkg::*;
(
    input  logic           clk,
    input  logic           nrst,
    input  logic [PRW-1:0] max_i,
    output logic           tick_o
);

    logic [PRW-1:0] pre_cnt;

    // >= rather than == so lowering max_i below the running count ticks at once instead of wrapping
    assign tick_o = (pre_cnt >= max_i);

    // Free-running count, restarted on every tick
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pre_cnt <= '0;
        end else if (tick_o) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRW'(1);
        end
    end

endmodule

// File: rtl/t06_tick_sched.sv
// rtl/t06_tick_sched.sv - periodic event scheduler with round-robin event handshake; T06_TICK_SCHED_ONESHOT_EN adds one-shot channels
module t06_tick_sched
    import t06_tick_pkg::*;
(
    input  logic           clk,
    input  logic           nrst,
    input  logic [PRW-1:0] max_i,
    input  logic           cfg_we,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [PW-1:0]  cfg_period,
    input  logic           cfg_en,
    input  logic           cfg_oneshot,
    input  logic           evt_ready_i,
    output logic           evt_valid_o,
    output logic [CHW-1:0] evt_ch_o,
    output logic [NCH-1:0] ovf_o,
    output logic           base_tick_o
);

    logic       base_tick;
    chan_cfg_t  cfg_q [NCH];
    period_t    cnt_q [NCH];
    logic [NCH-1:0] pending_q;
    logic [NCH-1:0] ovf_q;
    logic [NCH-1:0] wr_vec;
    logic [NCH-1:0] expire;
    logic [NCH-1:0] acc_vec;
    logic       wr_oneshot;

    arb_state_t arb_state_q;
    arb_state_t arb_state_d;
    ch_idx_t    ch_q;
    ch_idx_t    ch_d;
    ch_idx_t    rr_q;
    ch_idx_t    rr_d;
    logic       accept;
    logic       withdraw;

`ifdef T06_TICK_SCHED_ONESHOT_EN
    assign wr_oneshot = cfg_oneshot;
`else
    logic unused_cfg_oneshot;
    assign unused_cfg_oneshot = cfg_oneshot;
    assign wr_oneshot         = 1'b0;
`endif

    t06_prescaler u_prescaler (
        .clk    (clk),
        .nrst   (nrst),
        .max_i  (max_i),
        .tick_o (base_tick)
    );

    assign base_tick_o = base_tick;
    assign ovf_o       = ovf_q;
    assign evt_valid_o = (arb_state_q == ARB_GRANT);
    assign evt_ch_o    = ch_q;

    // Per-channel decode of config writes, expiries and handshake acceptance
    always_comb begin
        wr_vec  = '0;
        expire  = '0;
        acc_vec = '0;
        for (int c = 0; c < NCH; c++) begin
            wr_vec[c]  = cfg_we && (cfg_ch == ch_idx_t'(c));
            expire[c]  = base_tick && cfg_q[c].en && (cfg_q[c].reload != '0)
                         && (cnt_q[c] == period_t'(1));
            acc_vec[c] = accept && (ch_q == ch_idx_t'(c));
        end
    end

    // Channel counters, pending and overrun flags; a config write overrides everything on its channel
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int c = 0; c < NCH; c++) begin
                cfg_q[c] <= '0;
                cnt_q[c] <= '0;
            end
            pending_q <= '0;
            ovf_q     <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (wr_vec[c]) begin
                    cfg_q[c].reload  <= cfg_period;
                    cfg_q[c].en      <= cfg_en;
                    cfg_q[c].oneshot <= wr_oneshot;
                    cnt_q[c]         <= cfg_period;
                    pending_q[c]     <= 1'b0;
                    ovf_q[c]         <= 1'b0;
                end else begin
                    if (base_tick && cfg_q[c].en && (cfg_q[c].reload != '0)) begin
                        if (cnt_q[c] == period_t'(1)) begin
                            cnt_q[c] <= cfg_q[c].reload;
                        end else begin
                            cnt_q[c] <= cnt_q[c] - period_t'(1);
                        end
                    end
                    if (expire[c]) begin
                        // Expiry beats a same-cycle accept: the new event stays pending
                        pending_q[c] <= 1'b1;
                        if (pending_q[c] && !acc_vec[c]) begin
                            ovf_q[c] <= 1'b1;
                        end
                        if (cfg_q[c].oneshot) begin
                            cfg_q[c].en <= 1'b0;
                        end
                    end else if (acc_vec[c]) begin
                        pending_q[c] <= 1'b0;
                    end
                end
            end
        end
    end

    // Arbiter state, granted channel and round-robin pointer
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            arb_state_q <= ARB_IDLE;
            ch_q        <= '0;
            rr_q        <= '0;
        end else begin
            arb_state_q <= arb_state_d;
            ch_q        <= ch_d;
            rr_q        <= rr_d;
        end
    end

    // Arbiter next state: grant from idle, accept or withdraw from grant; always idles one clock between events
    always_comb begin
        arb_state_d = arb_state_q;
        ch_d        = ch_q;
        rr_d        = rr_q;
        accept      = 1'b0;
        withdraw    = cfg_we && (cfg_ch == ch_q);
        case (arb_state_q)
            ARB_IDLE: begin
                if (|pending_q) begin
                    arb_state_d = ARB_GRANT;
                    ch_d        = rr_pick(pending_q, rr_q);
                end
            end
            ARB_GRANT: begin
                if (withdraw) begin
                    arb_state_d = ARB_IDLE;
                end else if (evt_ready_i) begin
                    accept      = 1'b1;
                    arb_state_d = ARB_IDLE;
                    rr_d        = (ch_q == ch_idx_t'(NCH - 1)) ? '0 : ch_q + ch_idx_t'(1);
                end
            end
            default: begin
                arb_state_d = ARB_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_t06_tick_sched.sv
// tb/tb_t06_tick_sched.sv - directed self-checking bench for t06_tick_sched
module tb_t06_tick_sched;
    import t06_tick_pkg::*;

    logic           clk = 1'b0;
    logic           nrst = 1'b0;
    logic [PRW-1:0] max_i = '0;
    logic           cfg_we = 1'b0;
    logic [CHW-1:0] cfg_ch = '0;
    logic [PW-1:0]  cfg_period = '0;
    logic           cfg_en = 1'b0;
    logic           cfg_oneshot = 1'b0;
    logic           evt_ready_i = 1'b0;
    logic           evt_valid_o;
    logic [CHW-1:0] evt_ch_o;
    logic [NCH-1:0] ovf_o;
    logic           base_tick_o;

    int n_checks = 0;
    int n_errors = 0;

    t06_tick_sched dut (
        .clk         (clk),
        .nrst        (nrst),
        .max_i       (max_i),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_period  (cfg_period),
        .cfg_en      (cfg_en),
        .cfg_oneshot (cfg_oneshot),
        .evt_ready_i (evt_ready_i),
        .evt_valid_o (evt_valid_o),
        .evt_ch_o    (evt_ch_o),
        .ovf_o       (ovf_o),
        .base_tick_o (base_tick_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic do_reset(input logic [PRW-1:0] m);
        @(negedge clk);
        nrst        = 1'b0;
        max_i       = m;
        cfg_we      = 1'b0;
        evt_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic cfg_write(input int ch, input int period, input logic en, input logic os);
        cfg_we      = 1'b1;
        cfg_ch      = ch_idx_t'(ch);
        cfg_period  = period_t'(period);
        cfg_en      = en;
        cfg_oneshot = os;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    logic tick_hist [48];
    logic val_hist  [48];
    int   exp_ch    [5] = '{0, 1, 2, 3, 0};

    initial begin
        int ntick, nval, gap_bad, val_bad, gap8_bad, wide, last_t, last_v, cnt, first;

        // 1: max_i=3, ch0 period 2, ready high
        do_reset(19'd3);
        check("rst_valid", 32'(evt_valid_o), 0);
        check("rst_ch", 32'(evt_ch_o), 0);
        check("rst_ovf", 32'(ovf_o), 0);
        check("rst_tick", 32'(base_tick_o), 0);
        evt_ready_i = 1'b1;
        cfg_write(0, 2, 1'b1, 1'b0);
        for (int n = 0; n < 48; n++) begin
            tick_hist[n] = base_tick_o;
            val_hist[n]  = evt_valid_o;
            @(negedge clk);
        end
        ntick = 0; nval = 0; gap_bad = 0; val_bad = 0; gap8_bad = 0; wide = 0;
        last_t = -1; last_v = -1;
        for (int n = 0; n < 48; n++) begin
            if (tick_hist[n]) begin
                ntick++;
                if (last_t >= 0 && n - last_t != 4) gap_bad++;
                last_t = n;
            end
            if (val_hist[n]) begin
                nval++;
                if (n < 2 || !tick_hist[n-2]) val_bad++;
                if (last_v >= 0 && n - last_v != 8) gap8_bad++;
                if (n < 47 && val_hist[n+1]) wide++;
                last_v = n;
            end
        end
        check("t1_ntick", 32'(ntick), 12);
        check("t1_tick_gap", 32'(gap_bad), 0);
        check("t1_val_after_tick", 32'(val_bad), 0);
        check("t1_val_gap", 32'(gap8_bad), 0);
        check("t1_val_width", 32'(wide), 0);
        check("t1_nval_range", 32'(nval >= 5 && nval <= 6), 1);

        // 2: all channels period 1, tick every clock from cycle T
        do_reset(19'd100);
        evt_ready_i = 1'b1;
        for (int c = 0; c < NCH; c++) cfg_write(c, 1, 1'b1, 1'b0);
        max_i = '0;
        check("t2_valid_T", 32'(evt_valid_o), 0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k % 2 == 0) begin
                check($sformatf("t2_valid_%0d", k), 32'(evt_valid_o), 1);
                check($sformatf("t2_ch_%0d", k), 32'(evt_ch_o), 32'(exp_ch[k/2-1]));
            end else begin
                check($sformatf("t2_valid_%0d", k), 32'(evt_valid_o), 0);
            end
            if (k == 2) check("t2_ovf", 32'(ovf_o), 32'hF);
        end

        // 3: ch1 held without ready, overrun, then rewrite withdraws
        do_reset(19'd100);
        cfg_write(1, 1, 1'b1, 1'b0);
        max_i = '0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("t3_valid_1", 32'(evt_valid_o), 0);
            end else begin
                check($sformatf("t3_valid_%0d", k), 32'(evt_valid_o), 1);
                check($sformatf("t3_ch_%0d", k), 32'(evt_ch_o), 1);
                check($sformatf("t3_ovf_%0d", k), 32'(ovf_o), 32'h2);
            end
        end
        cfg_write(1, 1, 1'b0, 1'b0);
        check("t3_withdraw_valid", 32'(evt_valid_o), 0);
        check("t3_rewrite_ovf", 32'(ovf_o), 0);
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (evt_valid_o) cnt++;
        end
        check("t3_quiet", 32'(cnt), 0);

        // 4: period 0 never fires
        do_reset(19'd0);
        evt_ready_i = 1'b1;
        cfg_write(2, 0, 1'b1, 1'b0);
        cnt = 0; ntick = 0;
        for (int k = 0; k < 100; k++) begin
            if (evt_valid_o) cnt++;
            if (base_tick_o) ntick++;
            @(negedge clk);
        end
        check("t4_no_event", 32'(cnt), 0);
        check("t4_ticks", 32'(ntick), 100);
        check("t4_ovf", 32'(ovf_o), 0);

        // 5: write to ch3 on its expiry cycle wins; then async reset mid-handshake
        do_reset(19'd100);
        cfg_write(3, 1, 1'b1, 1'b0);
        max_i       = '0;
        cfg_we      = 1'b1;
        cfg_ch      = 2'd3;
        cfg_period  = 8'd3;
        cfg_en      = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
        check("t5_valid_1", 32'(evt_valid_o), 0);
        for (int k = 2; k <= 7; k++) begin
            @(negedge clk);
            if (k < 5) begin
                check($sformatf("t5_valid_%0d", k), 32'(evt_valid_o), 0);
            end else begin
                check($sformatf("t5_valid_%0d", k), 32'(evt_valid_o), 1);
                check($sformatf("t5_ch_%0d", k), 32'(evt_ch_o), 3);
            end
        end
        check("t5_ovf", 32'(ovf_o), 32'h8);
        #2 nrst = 1'b0;
        #1;
        check("t5_rst_valid", 32'(evt_valid_o), 0);
        check("t5_rst_ovf", 32'(ovf_o), 0);
        check("t5_rst_ch", 32'(evt_ch_o), 0);
        @(negedge clk);
        nrst = 1'b1;

`ifdef T06_TICK_SCHED_ONESHOT_EN
        // 6: one-shot channel fires exactly once
        do_reset(19'd100);
        evt_ready_i = 1'b1;
        cfg_write(0, 3, 1'b1, 1'b1);
        max_i = '0;
        cnt = 0; first = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (evt_valid_o) begin
                cnt++;
                if (first < 0) first = k;
            end
        end
        check("t6_count", 32'(cnt), 1);
        check("t6_first", 32'(first), 4);
`else
        first = 0;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
